// File: rtl/req_arbiter_8_if.sv
// Handshake bundle between eight requesters and the shared-resource arbiter.
// master = requester side, slave = arbiter side.
interface req_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_id, gnt_vld, timeout);
  modport slave  (input req, done, output gnt, gnt_id, gnt_vld, timeout);
endinterface

// File: rtl/req_arbiter_8.sv
// Eight-requester arbiter with registered one-hot grant, explicit release and hold watchdog.
// Define REQ_ARB_RR_EN for round-robin selection; default build is fixed priority (index 0 highest).
module req_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  req_arbiter_8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q;
  logic [7:0]       gnt_q, mask_q, mask_d, elig;
  logic [2:0]       gnt_id_q, win;
  logic             vld_q, timeout_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             hit_lim, own_req, release_c, wdog_c;

  assign elig = bus.req & ~mask_q;

`ifdef REQ_ARB_RR_EN
  logic [2:0] lp_q;

  // Search upward from lp+1; descending scan so the nearest index is written last.
  always_comb begin
    logic [2:0] idx;
    win = '0;
    idx = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = lp_q + 3'd1 + k[2:0];
      if (elig[idx]) win = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          lp_q <= 3'd7;
    else if (state_q == IDLE && |elig)   lp_q <= win;
`else
  always_comb begin
    win = '0;
    for (int i = 7; i >= 0; i--)
      if (elig[i]) win = 3'(i);
  end
`endif

  assign hit_lim   = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign own_req   = bus.req[gnt_id_q];
  assign release_c = bus.done || !own_req || hit_lim;
  // Watchdog only counts as a revoke when the grantee neither finished nor walked away.
  assign wdog_c    = (state_q == GRANT) && hit_lim && !bus.done && own_req;

  // A masked requester must drop req for one edge before it can compete again.
  always_comb begin
    mask_d = mask_q & bus.req;
    if (wdog_c) mask_d[gnt_id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      vld_q      <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      mask_q     <= '0;
    end else begin
      mask_q    <= mask_d;
      timeout_q <= wdog_c;
      case (state_q)
        IDLE: begin
          if (|elig) begin
            state_q    <= GRANT;
            gnt_q      <= 8'(1) << win;
            gnt_id_q   <= win;
            vld_q      <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (release_c) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            vld_q      <= 1'b0;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = vld_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed bench for req_arbiter_8 built with MAX_HOLD=4; picks the fixed or round-robin
// ordering test from REQ_ARB_RR_EN.
module tb_req_arbiter_8;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  req_arbiter_8_if bus ();

  req_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariant: gnt one-hot or zero, gnt_vld mirrors it.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (!$onehot0(bus.gnt) || (bus.gnt_vld !== (|bus.gnt))) begin
        fails++;
        $display("FAIL onehot: gnt=%h gnt_vld=%b", bus.gnt, bus.gnt_vld);
      end
    end
  end

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    repeat (2) tick();
    tests++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 3'd0 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: gnt=%h vld=%b id=%0d to=%b want 0", bus.gnt, bus.gnt_vld, bus.gnt_id, bus.timeout);
    end
    rst_n   = 1'b1;
    bus.req = 8'h04;
    tick();
    tests++;
    if (bus.gnt !== 8'h04 || bus.gnt_id !== 3'd2 || bus.gnt_vld !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_grant: gnt=%h id=%0d want 04 id 2", bus.gnt, bus.gnt_id);
    end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 3'd0) begin
      fails++;
      $display("FAIL reset_async: gnt=%h vld=%b want 00/0", bus.gnt, bus.gnt_vld);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.gnt !== 8'h04 || bus.gnt_vld !== 1'b1) begin
      fails++;
      $display("FAIL reset_regrant: gnt=%h want 04", bus.gnt);
    end
    bus.req = '0;
    repeat (2) tick();
  endtask

`ifndef REQ_ARB_RR_EN
  int fixed_ids[4] = '{1, 2, 5, 7};

  task automatic test_fixed();
    bus.req = 8'hA6;
    foreach (fixed_ids[n]) begin
      tick();
      for (int c = 0; c < 3; c++) begin
        tests++;
        if (bus.gnt !== (8'(1) << fixed_ids[n]) || bus.gnt_id !== 3'(fixed_ids[n])) begin
          fails++;
          $display("FAIL fixed_order[%0d] cyc %0d: gnt=%h id=%0d want id %0d", n, c, bus.gnt, bus.gnt_id, fixed_ids[n]);
        end
        if (c < 2) tick();
      end
      bus.done = 1'b1;
      bus.req[fixed_ids[n]] = 1'b0;
      tick();
      bus.done = 1'b0;
      tests++;
      if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
        fails++;
        $display("FAIL fixed_gap[%0d]: gnt=%h want 00", n, bus.gnt);
      end
    end
    tick();
  endtask
`else
  int rr_a[4] = '{0, 7, 0, 7};
  int rr_b[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  task automatic test_rr();
    bus.req = 8'h81;
    foreach (rr_a[n]) begin
      tick();
      tests++;
      if (bus.gnt_id !== 3'(rr_a[n]) || bus.gnt_vld !== 1'b1) begin
        fails++;
        $display("FAIL rr_81[%0d]: id=%0d vld=%b want %0d", n, bus.gnt_id, bus.gnt_vld, rr_a[n]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tests++;
      if (bus.gnt !== 8'h00) begin
        fails++;
        $display("FAIL rr_81_gap[%0d]: gnt=%h want 00", n, bus.gnt);
      end
    end
    bus.req = 8'hFF;
    foreach (rr_b[n]) begin
      tick();
      tests++;
      if (bus.gnt_id !== 3'(rr_b[n]) || bus.gnt_vld !== 1'b1) begin
        fails++;
        $display("FAIL rr_ff[%0d]: id=%0d want %0d", n, bus.gnt_id, rr_b[n]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
    bus.req = '0;
    tick();
  endtask
`endif

  task automatic test_no_preempt();
    bus.req = 8'h08;
    tick();
    bus.req = 8'h09;
    tick();
    tests++;
    if (bus.gnt !== 8'h08) begin
      fails++;
      $display("FAIL no_preempt: gnt=%h want 08", bus.gnt);
    end
    bus.done = 1'b1;
    bus.req  = 8'h01;
    tick();
    bus.done = 1'b0;
    tick();
    tests++;
    if (bus.gnt !== 8'h01 || bus.gnt_id !== 3'd0) begin
      fails++;
      $display("FAIL after_preempt: gnt=%h want 01", bus.gnt);
    end
    bus.req  = '0;
    bus.done = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.gnt !== 8'h00) begin
      fails++;
      $display("FAIL done_in_idle: gnt=%h want 00", bus.gnt);
    end
    bus.done = 1'b0;
  endtask

  task automatic test_watchdog();
    bus.req = 8'h10;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (bus.gnt !== 8'h10 || bus.timeout !== 1'b0) begin
        fails++;
        $display("FAIL wdog_hold cyc %0d: gnt=%h to=%b want 10/0", c, bus.gnt, bus.timeout);
      end
    end
    tick();
    tests++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b1) begin
      fails++;
      $display("FAIL wdog_revoke: gnt=%h to=%b want 00/1", bus.gnt, bus.timeout);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
        fails++;
        $display("FAIL wdog_masked cyc %0d: gnt=%h to=%b want 00/0", c, bus.gnt, bus.timeout);
      end
    end
    bus.req = 8'h00;
    tick();
    bus.req = 8'h10;
    tick();
    tests++;
    if (bus.gnt !== 8'h10) begin
      fails++;
      $display("FAIL wdog_unmask: gnt=%h want 10", bus.gnt);
    end
    bus.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_simul();
    bus.req = 8'h20;
    repeat (4) tick();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tests++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL simul_done: gnt=%h to=%b want 00/0", bus.gnt, bus.timeout);
    end
    tick();
    tests++;
    if (bus.gnt !== 8'h20) begin
      fails++;
      $display("FAIL simul_nomask: gnt=%h want 20", bus.gnt);
    end
    tick();
    bus.req = 8'h00;
    tick();
    tests++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL simul_reqdrop: gnt=%h to=%b want 00/0", bus.gnt, bus.timeout);
    end
    bus.req = 8'h20;
    repeat (4) tick();
    bus.req = 8'h00;
    tick();
    tests++;
    if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL simul_reqdrop_lim: gnt=%h to=%b want 00/0", bus.gnt, bus.timeout);
    end
    tick();
    tests++;
    if (bus.timeout !== 1'b0) begin
      fails++;
      $display("FAIL simul_no_late_to: to=%b want 0", bus.timeout);
    end
  endtask

  initial begin
    test_reset();
`ifdef REQ_ARB_RR_EN
    test_rr();
`else
    test_fixed();
`endif
    test_no_preempt();
    test_watchdog();
    test_simul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
